// File: rtl/onehot_wr_decoder_pkg.sv
// Shared defaults and width helpers for the one-hot write-strobe decoder.
package onehot_wr_decoder_pkg;
    localparam int SEL_W_DEF  = 5;
    localparam int NPORTS_DEF = 2;
    localparam int CNT_W_DEF  = 8;

    function automatic int out_w(input int sel_w);
        return 1 << sel_w;
    endfunction
endpackage

// File: rtl/onehot_wr_decoder_dec.sv
// Combinational SEL_W-to-2**SEL_W decoder; an idle port decodes to zero so
// unused select bits never reach the output.
module onehot_dec
    import onehot_wr_decoder_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic                     en_i,
    input  logic [SEL_W-1:0]         sel_i,
    output logic [out_w(SEL_W)-1:0]  dec_o
);
    always_comb begin
        dec_o = '0;
        if (en_i) dec_o[sel_i] = 1'b1;
    end
endmodule

// File: rtl/onehot_wr_decoder.sv
// Multi-port one-hot write-strobe decoder with lowest-port priority on
// same-select collisions, optional hold of the last strobe and a collision counter.
module onehot_wr_decoder
    import onehot_wr_decoder_pkg::*;
#(
    parameter int SEL_W     = SEL_W_DEF,
    parameter int NPORTS    = NPORTS_DEF,
    parameter bit ZERO_MASK = 1'b1,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NPORTS-1:0]         en,
    input  logic [NPORTS*SEL_W-1:0]   sel,
    input  logic                      hold,
    input  logic                      clr_conflict,
    output logic [out_w(SEL_W)-1:0]   data_out,
    output logic [NPORTS-1:0]         port_hit,
    output logic                      conflict,
    output logic                      conflict_sticky,
    output logic [CNT_W-1:0]          conflict_cnt
);
    localparam int OUT_W = out_w(SEL_W);

    logic [SEL_W-1:0]  sel_a [NPORTS];
    logic [OUT_W-1:0]  dec_a [NPORTS];
    logic [NPORTS-1:0] valid, win;
    logic              any_valid, collision;

    logic [OUT_W-1:0]  data_d, data_q;
    logic [NPORTS-1:0] hit_d, hit_q;
    logic              conf_d, conf_q;
    logic              sticky_d, sticky_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        assign sel_a[p] = sel[p*SEL_W +: SEL_W];
        assign valid[p] = en[p] && !(ZERO_MASK && (sel_a[p] == '0));

        onehot_dec #(.SEL_W(SEL_W)) u_dec (
            .en_i  (win[p]),
            .sel_i (sel_a[p]),
            .dec_o (dec_a[p])
        );
    end

    // A port wins unless a lower-indexed valid port targets the same select.
    always_comb begin
        win       = valid;
        collision = 1'b0;
        for (int p = 1; p < NPORTS; p++) begin
            for (int q = 0; q < p; q++) begin
                if (valid[p] && valid[q] && (sel_a[p] == sel_a[q])) begin
                    win[p]    = 1'b0;
                    collision = 1'b1;
                end
            end
        end
    end

    always_comb begin
        any_valid = |valid;
        data_d    = '0;
        for (int p = 0; p < NPORTS; p++) data_d = data_d | dec_a[p];
        if (!any_valid && hold) data_d = data_q;
        hit_d  = win;
        conf_d = collision;
    end

    // Collision in the same cycle as a clear restarts the count at one.
    always_comb begin
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (clr_conflict) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end
        if (collision) begin
            sticky_d = 1'b1;
            if (clr_conflict)        cnt_d = CNT_W'(1);
            else if (cnt_q != '1)    cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            hit_q    <= '0;
            conf_q   <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            data_q   <= data_d;
            hit_q    <= hit_d;
            conf_q   <= conf_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign data_out        = data_q;
    assign port_hit        = hit_q;
    assign conflict        = conf_q;
    assign conflict_sticky = sticky_q;
    assign conflict_cnt    = cnt_q;
endmodule

// File: tb/tb_onehot_wr_decoder.sv
// Directed bench: default-width decoder plus a CNT_W=2 copy on the same inputs
// for counter saturation.
module tb_onehot_wr_decoder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  en;
    logic [9:0]  sel;
    logic        hold, clr_conflict;

    logic [31:0] data_out, d2_data;
    logic [1:0]  port_hit, d2_hit;
    logic        conflict, sticky, d2_conf, d2_sticky;
    logic [7:0]  cnt;
    logic [1:0]  d2_cnt;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clk = ~clk;

    onehot_wr_decoder dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .hold(hold),
        .clr_conflict(clr_conflict), .data_out(data_out), .port_hit(port_hit),
        .conflict(conflict), .conflict_sticky(sticky), .conflict_cnt(cnt)
    );

    onehot_wr_decoder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .sel(sel), .hold(hold),
        .clr_conflict(clr_conflict), .data_out(d2_data), .port_hit(d2_hit),
        .conflict(d2_conf), .conflict_sticky(d2_sticky), .conflict_cnt(d2_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [1:0] e, input logic [4:0] s0, input logic [4:0] s1,
                       input logic h, input logic c);
        en = e; sel = {s1, s0}; hold = h; clr_conflict = c;
    endtask

    // Capture on the next rising edge, then sample on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},   64'(data_out), 64'h0);
        chk({tag, "_hit"},    64'(port_hit), 64'h0);
        chk({tag, "_conf"},   64'(conflict), 64'h0);
        chk({tag, "_sticky"}, 64'(sticky),   64'h0);
        chk({tag, "_cnt"},    64'(cnt),      64'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        req(2'b11, 5'd3, 5'd9, 1'b1, 1'b0);
        tick(); tick();
        chk_all_zero("reset");

        rst_n = 1'b1;
        tick();
        chk("multi_data", 64'(data_out), 64'h0000_0208);
        chk("multi_hit",  64'(port_hit), 64'h3);
        chk("multi_conf", 64'(conflict), 64'h0);

        req(2'b11, 5'd7, 5'd7, 1'b0, 1'b0);
        tick();
        chk("coll_data",   64'(data_out), 64'h0000_0080);
        chk("coll_hit",    64'(port_hit), 64'h1);
        chk("coll_conf",   64'(conflict), 64'h1);
        chk("coll_sticky", 64'(sticky),   64'h1);
        chk("coll_cnt",    64'(cnt),      64'h1);

        req(2'b00, 5'd7, 5'd7, 1'b0, 1'b0);
        tick();
        chk("idle_data",   64'(data_out), 64'h0);
        chk("pulse_end",   64'(conflict), 64'h0);
        chk("sticky_keep", 64'(sticky),   64'h1);

        req(2'b01, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("zmask_data", 64'(data_out), 64'h0);
        chk("zmask_hit",  64'(port_hit), 64'h0);
        req(2'b11, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("zmask_conf", 64'(conflict), 64'h0);
        chk("zmask_cnt",  64'(cnt),      64'h1);

        req(2'b00, 5'd0, 5'd0, 1'b0, 1'b1);
        tick();
        chk("clr_sticky", 64'(sticky), 64'h0);
        chk("clr_cnt",    64'(cnt),    64'h0);
        chk("clr_cnt2",   64'(d2_cnt), 64'h0);

        req(2'b01, 5'd31, 5'd0, 1'b0, 1'b0);
        tick();
        chk("sel31_data", 64'(data_out), 64'h8000_0000);
        chk("sel31_hit",  64'(port_hit), 64'h1);
        for (int i = 0; i < 3; i++) begin
            req(2'b00, 5'd31, 5'd0, 1'b1, 1'b0);
            tick();
            chk($sformatf("hold%0d_data", i), 64'(data_out), 64'h8000_0000);
            chk($sformatf("hold%0d_hit", i),  64'(port_hit), 64'h0);
        end
        req(2'b00, 5'd31, 5'd0, 1'b0, 1'b0);
        tick();
        chk("unhold_data", 64'(data_out), 64'h0);

        req(2'b01, 5'd4, 5'd0, 1'b1, 1'b0);
        tick();
        req(2'b10, 5'd4, 5'd1, 1'b1, 1'b0);
        tick();
        chk("override_data", 64'(data_out), 64'h0000_0002);
        chk("override_hit",  64'(port_hit), 64'h2);

        for (int i = 0; i < 5; i++) begin
            req(2'b11, 5'd2, 5'd2, 1'b0, 1'b0);
            tick();
            chk($sformatf("sat%0d_cnt2", i), 64'(d2_cnt), (i < 3) ? 64'(i + 1) : 64'h3);
            chk($sformatf("sat%0d_cnt", i),  64'(cnt),    64'(i + 1));
        end
        req(2'b11, 5'd2, 5'd2, 1'b0, 1'b1);
        tick();
        chk("clrcoll_cnt2",   64'(d2_cnt),    64'h1);
        chk("clrcoll_sticky", 64'(d2_sticky), 64'h1);
        chk("clrcoll_cnt",    64'(cnt),       64'h1);
        chk("clrcoll_conf",   64'(conflict),  64'h1);

        req(2'b01, 5'd4, 5'd0, 1'b1, 1'b0);
        tick();
        req(2'b00, 5'd4, 5'd0, 1'b1, 1'b0);
        tick();
        chk("prerst_data", 64'(data_out), 64'h10);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("postrst_hold", 64'(data_out), 64'h0);
        req(2'b01, 5'd5, 5'd0, 1'b0, 1'b0);
        tick();
        chk("postrst_data", 64'(data_out), 64'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
